// File: rtl/udp_stream_pkg.sv
// rtl/udp_stream_pkg.sv - shared stream constants, scheduler state type and clog2 helper
package udp_stream_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority picker, search starts after last_grant
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant,
    output logic         any
);

    logic [W-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last_grant) + i) % N);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - packet round-robin egress scheduler with inter-packet gap and per-source counters
module udp_tx_scheduler
    import udp_stream_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = AXIS_DATA_W,
    parameter int IPG_W  = 16
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_aresetn,
    input  logic [N_SRC*DATA_W-1:0]    s_axis_tdata,
    input  logic [N_SRC*DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [N_SRC-1:0]           s_axis_tvalid,
    input  logic [N_SRC-1:0]           s_axis_tlast,
    output logic [N_SRC-1:0]           s_axis_tready,
    output logic [DATA_W-1:0]          m00_axis_tdata,
    output logic [DATA_W/8-1:0]        m00_axis_tkeep,
    output logic                       m00_axis_tvalid,
    output logic                       m00_axis_tlast,
    input  logic                       m00_axis_tready,
    input  logic [N_SRC-1:0]           cfg_enable,
    input  logic [IPG_W-1:0]           cfg_ipg,
    output logic [N_SRC*32-1:0]        stat_pkt_cnt,
    output logic [clog2(N_SRC)-1:0]    stat_grant,
    output logic                       busy
);

    localparam int GW = clog2(N_SRC);

    sched_state_t        state, state_nxt;
    logic [GW-1:0]       grant, last_grant, arb_grant;
    logic                arb_any;
    logic [N_SRC-1:0]    arb_req;
    logic [IPG_W-1:0]    gap_cnt;
    logic                eop_hs;
    logic [31:0]         pkt_cnt  [N_SRC];
    logic [DATA_W-1:0]   src_data [N_SRC];
    logic [DATA_W/8-1:0] src_keep [N_SRC];

    genvar k;
    generate
        for (k = 0; k < N_SRC; k++) begin : g_src
            assign src_data[k] = s_axis_tdata[k*DATA_W +: DATA_W];
            assign src_keep[k] = s_axis_tkeep[k*(DATA_W/8) +: DATA_W/8];
            assign stat_pkt_cnt[k*32 +: 32] = pkt_cnt[k];
        end
    endgenerate

    assign arb_req = s_axis_tvalid & cfg_enable;

    rr_arbiter #(.N(N_SRC), .W(GW)) u_rr_arbiter (
        .req        (arb_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    assign eop_hs = (state == SEND) && s_axis_tvalid[grant] && s_axis_tlast[grant] && m00_axis_tready;
    assign busy   = (state != IDLE);

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset last_grant to the top index so the first search starts at source 0.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            grant      <= '0;
            last_grant <= GW'(N_SRC - 1);
            stat_grant <= '0;
            gap_cnt    <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant      <= arb_grant;
                        stat_grant <= arb_grant;
                    end
                end
                SEND: begin
                    if (eop_hs) begin
                        pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
                        last_grant     <= grant;
                        gap_cnt        <= cfg_ipg;
                    end
                end
                GAP: gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        s_axis_tready   = '0;
        m00_axis_tdata  = '0;
        m00_axis_tkeep  = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m00_axis_tdata       = src_data[grant];
                m00_axis_tkeep       = src_keep[grant];
                m00_axis_tvalid      = s_axis_tvalid[grant];
                m00_axis_tlast       = s_axis_tlast[grant];
                s_axis_tready[grant] = m00_axis_tready;
                if (eop_hs) begin
                    state_nxt = (cfg_ipg != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt <= IPG_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - directed self-checking bench for udp_tx_scheduler
module tb_udp_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N*KW-1:0] s_axis_tkeep = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [N-1:0]    s_axis_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready = 1'b1;
    logic [N-1:0]    cfg_enable = '0;
    logic [15:0]     cfg_ipg = '0;
    logic [N*32-1:0] stat_pkt_cnt;
    logic [1:0]      stat_grant;
    logic            busy;

    always #5 clk = ~clk;

    udp_tx_scheduler #(.N_SRC(N), .DATA_W(DW), .IPG_W(16)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (resetn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tkeep   (m_tkeep),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tready  (m_tready),
        .cfg_enable       (cfg_enable),
        .cfg_ipg          (cfg_ipg),
        .stat_pkt_cnt     (stat_pkt_cnt),
        .stat_grant       (stat_grant),
        .busy             (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_len [N];
    int gen_rem [N];
    int gen_beat[N];
    int gen_pkt [N];
    logic [N-1:0] hs;
    logic [63:0]  log_data[64];
    logic         log_last[64];
    logic [7:0]   log_keep[64];
    int           log_cyc [64];
    int           log_n = 0;
    logic         rdy_hist[1024];
    logic         vld_hist[1024];
    logic [3:0]   rdy_pat = 4'b1001;
    logic         pat_on = 1'b0;
    int           pat_t0 = 0;
    logic         prev_stall = 1'b0;
    logic [63:0]  prev_data = '0;
    int           stall_cnt = 0;
    int           unstable_cnt = 0;
    int           t0, e, bad;
    int           seq5[8] = '{1, 3, 1, 3, 1, 3, 3, 3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] enc(input int k, input int p, input int b);
        return {8'(k), 24'(p), 32'(b)};
    endfunction

    task automatic drive_src();
        for (int k = 0; k < N; k++) begin
            s_axis_tvalid[k]          = (gen_rem[k] > 0);
            s_axis_tlast[k]           = (gen_beat[k] == gen_len[k] - 1);
            s_axis_tdata[k*DW +: DW]  = enc(k, gen_pkt[k], gen_beat[k]);
            s_axis_tkeep[k*KW +: KW]  = s_axis_tlast[k] ? 8'h0F : 8'hFF;
        end
        m_tready = pat_on ? rdy_pat[(cyc - pat_t0) & 3] : 1'b1;
    endtask

    task automatic clear_gens();
        for (int k = 0; k < N; k++) begin
            gen_len[k] = 4; gen_rem[k] = 0; gen_beat[k] = 0; gen_pkt[k] = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        rdy_hist[cyc % 1024] = |s_axis_tready;
        vld_hist[cyc % 1024] = m_tvalid;
        if (m_tvalid && m_tready && log_n < 64) begin
            log_data[log_n] = m_tdata;
            log_last[log_n] = m_tlast;
            log_keep[log_n] = m_tkeep;
            log_cyc[log_n]  = cyc;
            log_n++;
        end
        if (prev_stall && m_tvalid && m_tdata !== prev_data) unstable_cnt++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        if (prev_stall) stall_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hs[k]) begin
                if (gen_beat[k] == gen_len[k] - 1) begin
                    gen_beat[k] = 0; gen_pkt[k]++; gen_rem[k]--;
                end else begin
                    gen_beat[k]++;
                end
            end
        end
        drive_src();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_gens();
        drive_src();
        cycle();
        cycle();
        resetn = 1'b1;
        log_n = 0;
    endtask

    initial begin
        clear_gens();
        for (int k = 0; k < N; k++) gen_rem[k] = 1;
        drive_src();
        #1;
        // Reset state with every source offering data.
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(stat_grant), 64'd0);
        chk("rst_cnt", stat_pkt_cnt, 64'd0);

        // Single 4-beat packet from source 0.
        do_reset();
        cfg_enable = 4'b0001; cfg_ipg = 16'd0;
        gen_len[0] = 4; gen_rem[0] = 1;
        drive_src();
        t0 = cyc;
        repeat (8) cycle();
        chk("t1_beats", 64'(log_n), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_cyc", 64'(log_cyc[i]), 64'(t0 + 1 + i));
            chk("t1_data", log_data[i], enc(0, 0, i));
            chk("t1_last", 64'(log_last[i]), 64'(i == 3));
        end
        chk("t1_keep_last", 64'(log_keep[3]), 64'h0F);
        chk("t1_cnt0", 64'(stat_pkt_cnt[31:0]), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // Two continuous sources alternate packet by packet.
        do_reset();
        cfg_enable = 4'b0011;
        gen_len[0] = 3; gen_rem[0] = 5;
        gen_len[1] = 3; gen_rem[1] = 5;
        drive_src();
        for (int i = 0; i < 200 && log_n < 30; i++) cycle();
        chk("t2_beats", 64'(log_n), 64'd30);
        for (int p = 0; p < 10; p++) begin
            for (int b = 0; b < 3; b++) begin
                chk("t2_order", log_data[p*3 + b], enc(p % 2, p / 2, b));
            end
        end
        chk("t2_cnt0", 64'(stat_pkt_cnt[31:0]), 64'd5);
        chk("t2_cnt1", 64'(stat_pkt_cnt[63:32]), 64'd5);

        // Inter-packet gap of 3 on source 2.
        do_reset();
        cfg_enable = 4'b0100; cfg_ipg = 16'd3;
        gen_len[2] = 2; gen_rem[2] = 2;
        drive_src();
        for (int i = 0; i < 100 && log_n < 4; i++) cycle();
        repeat (2) cycle();
        chk("t3_beats", 64'(log_n), 64'd4);
        chk("t3_last", 64'(log_last[1]), 64'd1);
        e = log_cyc[1];
        chk("t3_gap", 64'(log_cyc[2] - e), 64'd5);
        bad = 0;
        for (int c = e + 1; c <= e + 4; c++) begin
            if (rdy_hist[c % 1024] !== 1'b0 || vld_hist[c % 1024] !== 1'b0) bad++;
        end
        chk("t3_quiet", 64'(bad), 64'd0);
        chk("t3_cnt2", 64'(stat_pkt_cnt[95:64]), 64'd2);

        // Egress backpressure 1,0,0,1 repeating over a 4-beat packet.
        do_reset();
        cfg_enable = 4'b0001; cfg_ipg = 16'd0;
        gen_len[0] = 4; gen_rem[0] = 1;
        t0 = cyc;
        pat_t0 = t0 + 1;
        pat_on = 1'b1;
        stall_cnt = 0; unstable_cnt = 0; prev_stall = 1'b0;
        drive_src();
        repeat (12) cycle();
        pat_on = 1'b0;
        chk("t4_beats", 64'(log_n), 64'd4);
        for (int i = 0; i < 4; i++) chk("t4_data", log_data[i], enc(0, 0, i));
        chk("t4_stalls", 64'(stall_cnt), 64'd4);
        chk("t4_stable", 64'(unstable_cnt), 64'd0);
        chk("t4_lastcyc", 64'(log_cyc[3]), 64'(t0 + 8));

        // Enable mask 1010, then drop source 1 mid-packet.
        do_reset();
        cfg_enable = 4'b1010;
        for (int k = 0; k < N; k++) begin
            gen_len[k] = 3; gen_rem[k] = 20;
        end
        drive_src();
        for (int i = 0; i < 200 && log_n < 13; i++) cycle();
        cfg_enable = 4'b1000;
        for (int i = 0; i < 200 && log_n < 24; i++) cycle();
        chk("t5_beats", 64'(log_n), 64'd24);
        for (int i = 0; i < 24; i++) begin
            chk("t5_seq", {24'd0, log_data[i][63:56], log_data[i][31:0]},
                {24'd0, 8'(seq5[i / 3]), 32'(i % 3)});
        end

        // Reset in the middle of a packet.
        do_reset();
        cfg_enable = 4'b0001; cfg_ipg = 16'd0;
        gen_len[0] = 4; gen_rem[0] = 2;
        drive_src();
        for (int i = 0; i < 100 && log_n < 6; i++) cycle();
        chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
        chk("t6_pre_cnt", 64'(stat_pkt_cnt[31:0]), 64'd1);
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_cnt", 64'(stat_pkt_cnt[31:0]), 64'd0);
        chk("t6_rst_ready", 64'(s_axis_tready), 64'd0);
        clear_gens();
        drive_src();
        cycle();
        cycle();
        resetn = 1'b1;
        log_n = 0;
        gen_len[0] = 4; gen_rem[0] = 1;
        drive_src();
        t0 = cyc;
        repeat (8) cycle();
        chk("t6_beats", 64'(log_n), 64'd4);
        chk("t6_first", 64'(log_cyc[0]), 64'(t0 + 1));
        chk("t6_grant", 64'(stat_grant), 64'd0);
        chk("t6_cnt0", 64'(stat_pkt_cnt[31:0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
